// File: rtl/mux_readback_pkg.sv
// Shared definitions for the mux readback block: Mux select codes,
// readback FSM state encoding and the settle counter width.
package mux_readback_pkg;

  // Mux select codes; captures follow this order, byte k <- select k
  localparam logic [1:0] MUX_SEL_COUNTER_CARRY  = 2'd0;
  localparam logic [1:0] MUX_SEL_COUNTER_VALUE  = 2'd1;
  localparam logic [1:0] MUX_SEL_REGISTER_2_MSB = 2'd2;
  localparam logic [1:0] MUX_SEL_REGISTER_2_LSB = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } rb_state_e;

  // settle counter is 4 bits wide, so SETTLE_CYCLES is legal in 1..15
  localparam int SETTLE_W = 4;

  function automatic logic [SETTLE_W-1:0] settle_load(input int cycles);
    return SETTLE_W'(cycles);
  endfunction

endpackage

// File: rtl/mux_readback_if.sv
// Mux-side and frame-side signals of the readback block.
// Optional: MUX_READBACK_PARITY_EN adds frame_parity.
interface mux_readback_if #(parameter int DATA_WIDTH = 8);
  logic                    start;
  logic                    busy;
  logic [1:0]              mux_sel;
  logic [DATA_WIDTH-1:0]   mux_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [4*DATA_WIDTH-1:0] frame_data;
`ifdef MUX_READBACK_PARITY_EN
  logic                    frame_parity;
`endif

  // readback block side
  modport master (
    input  start, mux_data, frame_ready,
    output busy, mux_sel, frame_valid, frame_data
`ifdef MUX_READBACK_PARITY_EN
    , output frame_parity
`endif
  );

  // host / Mux side
  modport slave (
    output start, mux_data, frame_ready,
    input  busy, mux_sel, frame_valid, frame_data
`ifdef MUX_READBACK_PARITY_EN
    , input frame_parity
`endif
  );
endinterface

// File: rtl/mux_readback_settle.sv
// Loadable down-counter; capture strobes while count==1, i.e. on the
// last edge of a settle window. Stops at zero when not reloaded.
module mux_readback_settle
  import mux_readback_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                capture
);

  logic [SETTLE_W-1:0] count;

  // load wins over decrement so back-to-back windows have no gap
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign capture = (count == SETTLE_W'(1));

endmodule

// File: rtl/mux_readback.sv
// Readback sequencer for the 4:1 output Mux: steps the select through all
// four sources, captures each after SETTLE_CYCLES, and offers the packed
// 32-bit frame on a valid/ready handshake.
// Optional: MUX_READBACK_PARITY_EN adds frame_parity (XOR of frame bits).
module mux_readback
  import mux_readback_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_WIDTH    = 8
)(
  input  logic           clk,
  input  logic           reset,
  mux_readback_if.master bus
);

  rb_state_e state, state_nxt;
  logic      accept, load, cap, last, handshake, capture;

  mux_readback_settle u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (settle_load(SETTLE_CYCLES)),
    .capture  (capture)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and per-edge control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    cap       = 1'b0;
    handshake = 1'b0;
    last      = (bus.mux_sel == MUX_SEL_REGISTER_2_LSB);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (capture) begin
          cap = 1'b1;
          if (last) state_nxt = VALID;
          else      load      = 1'b1;
        end
      end
      VALID: begin
        if (bus.frame_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // select, status and frame packing; frame_data keeps the last frame
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.busy        <= 1'b0;
      bus.mux_sel     <= MUX_SEL_COUNTER_CARRY;
      bus.frame_valid <= 1'b0;
      bus.frame_data  <= '0;
`ifdef MUX_READBACK_PARITY_EN
      bus.frame_parity <= 1'b0;
`endif
    end else begin
      if (accept) begin
        bus.busy    <= 1'b1;
        bus.mux_sel <= MUX_SEL_COUNTER_CARRY;
      end
      if (cap) begin
        bus.frame_data[DATA_WIDTH*int'(bus.mux_sel) +: DATA_WIDTH] <= bus.mux_data;
        if (last) begin
          bus.frame_valid <= 1'b1;
`ifdef MUX_READBACK_PARITY_EN
          // final byte is not yet in frame_data, so fold it in here
          bus.frame_parity <= ^{bus.mux_data, bus.frame_data[3*DATA_WIDTH-1:0]};
`endif
        end else begin
          bus.mux_sel <= bus.mux_sel + 2'd1;
        end
      end
      if (handshake) begin
        bus.frame_valid <= 1'b0;
        bus.busy        <= 1'b0;
        bus.mux_sel     <= MUX_SEL_COUNTER_CARRY;
      end
    end
  end

endmodule

// File: tb/tb_mux_readback.sv
// Bench for mux_readback: two instances (SETTLE_CYCLES 1 and 3) driven in
// lockstep from a behavioural Mux and compared every cycle against a
// timing model derived from the start edge and the settle length.
module tb_mux_readback;
  localparam int DW = 8;

  logic clk, rst, start, ready;
  logic [7:0] s_cnt, s_msb, s_lsb;
  logic       s_carry;

  int n_chk = 0, n_err = 0, edge_n = 0;

  mux_readback_if #(.DATA_WIDTH(DW)) if1 ();
  mux_readback_if #(.DATA_WIDTH(DW)) if3 ();

  mux_readback #(.SETTLE_CYCLES(1), .DATA_WIDTH(DW)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));
  mux_readback #(.SETTLE_CYCLES(3), .DATA_WIDTH(DW)) u_dut3 (.clk(clk), .reset(rst), .bus(if3));

  function automatic logic [7:0] mux_fn(input logic [1:0] k, input logic c,
                                        input logic [7:0] cv, input logic [7:0] mv, input logic [7:0] lv);
    case (k)
      2'd0:    return {7'b0, c};
      2'd1:    return cv;
      2'd2:    return mv;
      default: return lv;
    endcase
  endfunction

  assign if1.start = start;  assign if1.frame_ready = ready;
  assign if3.start = start;  assign if3.frame_ready = ready;
  assign if1.mux_data = mux_fn(if1.mux_sel, s_carry, s_cnt, s_msb, s_lsb);
  assign if3.mux_data = mux_fn(if3.mux_sel, s_carry, s_cnt, s_msb, s_lsb);

  logic [1:0]  sel_o   [2];
  logic        busy_o  [2];
  logic        valid_o [2];
  logic [31:0] frame_o [2];
  assign sel_o[0] = if1.mux_sel;  assign sel_o[1] = if3.mux_sel;
  assign busy_o[0] = if1.busy;    assign busy_o[1] = if3.busy;
  assign valid_o[0] = if1.frame_valid; assign valid_o[1] = if3.frame_valid;
  assign frame_o[0] = if1.frame_data;  assign frame_o[1] = if3.frame_data;
`ifdef MUX_READBACK_PARITY_EN
  logic par_o [2];
  assign par_o[0] = if1.frame_parity; assign par_o[1] = if3.frame_parity;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: a run started at edge e0 captures byte k at edge e0+(k+1)*S
  bit          m_busy  [2];
  bit          m_valid [2];
  bit          m_par   [2];
  int          m_e0    [2];
  logic [31:0] m_frame [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int s, j, k;
    s = settle_of(i);
    if (rst) begin
      m_busy[i] = 0; m_valid[i] = 0; m_par[i] = 0; m_frame[i] = '0;
    end else if (!m_busy[i]) begin
      if (start) begin m_busy[i] = 1; m_e0[i] = edge_n; end
    end else if (m_valid[i]) begin
      if (ready) begin m_valid[i] = 0; m_busy[i] = 0; end
    end else begin
      j = edge_n - m_e0[i];
      if (j % s == 0) begin
        k = j / s - 1;
        m_frame[i][k*8 +: 8] = mux_fn(2'(k), s_carry, s_cnt, s_msb, s_lsb);
        if (k == 3) begin m_valid[i] = 1; m_par[i] = ^m_frame[i]; end
      end
    end
  endtask

  task automatic compare(input int i);
    int exp_sel;
    if (!m_busy[i])      exp_sel = 0;
    else if (m_valid[i]) exp_sel = 3;
    else                 exp_sel = (edge_n - m_e0[i]) / settle_of(i);
    check($sformatf("d%0d sel", i),   64'(sel_o[i]),   64'(exp_sel));
    check($sformatf("d%0d busy", i),  64'(busy_o[i]),  64'(m_busy[i]));
    check($sformatf("d%0d valid", i), 64'(valid_o[i]), 64'(m_valid[i]));
    check($sformatf("d%0d frame", i), 64'(frame_o[i]), 64'(m_frame[i]));
`ifdef MUX_READBACK_PARITY_EN
    check($sformatf("d%0d parity", i), 64'(par_o[i]), 64'(m_par[i]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  task automatic wait_valid(input int i);
    int n;
    n = 0;
    while (!valid_o[i] && n < 100) begin tick(); n++; end
    if (!valid_o[i]) check($sformatf("d%0d valid timeout", i), 64'(valid_o[i]), 64'd1);
  endtask

  task automatic set_src(input logic c, input logic [7:0] cv, input logic [7:0] mv, input logic [7:0] lv);
    s_carry = c; s_cnt = cv; s_msb = mv; s_lsb = lv;
  endtask

  task automatic pulse_ready();
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    set_src(1'b1, 8'haa, 8'hbe, 8'hef);
    repeat (3) tick();
    check("reset frame", 64'(frame_o[0]), 64'd0);
    rst = 1'b0;
    tick();

    // basic frame, then backpressure
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(1);
    check("basic d0", 64'(frame_o[0]), 64'h00000000EFBEAA01);
    check("basic d1", 64'(frame_o[1]), 64'h00000000EFBEAA01);
`ifdef MUX_READBACK_PARITY_EN
    check("basic parity", 64'(par_o[0]), 64'd0);
`endif
    repeat (10) tick();
    check("hold frame", 64'(frame_o[0]), 64'h00000000EFBEAA01);
    check("hold sel", 64'(sel_o[0]), 64'd3);
    pulse_ready();
    check("after hs valid", 64'(valid_o[0]), 64'd0);
    check("after hs busy", 64'(busy_o[1]), 64'd0);
    tick();

    // start during WAIT and on the handshake edge is ignored
    set_src(1'b0, 8'h3c, 8'h5a, 8'hc3);
    start = 1'b1; tick(); start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(0);
    ready = 1'b1; start = 1'b1; tick(); ready = 1'b0; start = 1'b0;
    repeat (3) tick();
    check("no rerun d0", 64'(busy_o[0]), 64'd0);
    wait_valid(1);
    pulse_ready();
    tick();

    // reset after the second capture of the fast instance
    set_src(1'b1, 8'h11, 8'h22, 8'h33);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst frame d0", 64'(frame_o[0]), 64'd0);
    check("rst busy d1", 64'(busy_o[1]), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(1);
    check("post rst frame", 64'(frame_o[1]), 64'h0000000033221101);
    pulse_ready();

    // odd-parity vector
    set_src(1'b0, 8'h01, 8'h00, 8'h00);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(1);
    check("par frame", 64'(frame_o[0]), 64'h0000000000000100);
`ifdef MUX_READBACK_PARITY_EN
    check("par bit", 64'(par_o[1]), 64'd1);
`endif
    pulse_ready();

    // random: sources change every cycle, random start/ready, rare reset
    for (int c = 0; c < 2000; c++) begin
      set_src(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    start = 1'b0; rst = 1'b0; ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
